// File: rtl/xif_copro_responder.sv
// Reference CV-X-IF coprocessor: accepts a small custom ALU instruction set,
// gathers operands, waits for commit/kill and returns results strictly in issue order.
module xif_copro_responder #(
  parameter int X_ID_WIDTH = 4,
  parameter int XLEN       = 32,
  parameter int DEPTH      = 4,
  parameter int LATENCY    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [31:0]           issue_instr_i,
  input  logic [X_ID_WIDTH-1:0] issue_id_i,
  output logic                  issue_accept_o,
  output logic                  issue_writeback_o,
  input  logic                  register_valid_i,
  output logic                  register_ready_o,
  input  logic [X_ID_WIDTH-1:0] register_id_i,
  input  logic [XLEN-1:0]       register_rs0_i,
  input  logic [XLEN-1:0]       register_rs1_i,
  input  logic [1:0]            register_rs_valid_i,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [X_ID_WIDTH-1:0] result_id_o,
  output logic [XLEN-1:0]       result_data_o,
  output logic [4:0]            result_rd_o,
  output logic                  result_we_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d, idx;
  logic [PW:0]           count_q, count_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DEPTH-1:0]      valid_q, valid_d, ops_ok_q, ops_ok_d;
  logic [DEPTH-1:0]      committed_q, committed_d, killed_q, killed_d;
  logic [X_ID_WIDTH-1:0] id_q [DEPTH];
  logic [X_ID_WIDTH-1:0] id_d [DEPTH];
  logic [2:0]            f3_q [DEPTH];
  logic [2:0]            f3_d [DEPTH];
  logic [4:0]            rd_q [DEPTH];
  logic [4:0]            rd_d [DEPTH];
  logic [XLEN-1:0]       rs1_q [DEPTH];
  logic [XLEN-1:0]       rs1_d [DEPTH];
  logic [XLEN-1:0]       rs2_q [DEPTH];
  logic [XLEN-1:0]       rs2_d [DEPTH];
  logic                  dec_ok, alloc, pop, reg_hit, cmt_hit;
  logic [XLEN-1:0]       exec_res;

  assign dec_ok = (issue_instr_i[6:0] == 7'b0001011) && (issue_instr_i[31:25] == 7'd0) &&
                  (issue_instr_i[14:12] <= 3'd2);
  assign issue_accept_o    = issue_valid_i & dec_ok;
  assign issue_writeback_o = issue_accept_o;
  assign issue_ready_o     = (count_q < (PW+1)'(DEPTH));
  assign register_ready_o  = 1'b1;
  assign alloc             = issue_valid_i & issue_ready_o & dec_ok;

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    ops_ok_d    = ops_ok_q;
    committed_d = committed_q;
    killed_d    = killed_q;
    id_d        = id_q;
    f3_d        = f3_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    idx         = '0;
    reg_hit     = 1'b0;
    cmt_hit     = 1'b0;
    pop         = 1'b0;

    if (alloc) begin
      valid_d[tail_q]     = 1'b1;
      id_d[tail_q]        = issue_id_i;
      f3_d[tail_q]        = issue_instr_i[14:12];
      rd_d[tail_q]        = issue_instr_i[11:7];
      ops_ok_d[tail_q]    = 1'b0;
      committed_d[tail_q] = 1'b0;
      killed_d[tail_q]    = 1'b0;
      tail_d              = tail_q + PW'(1);
    end

    // Existing entries win; the entry being allocated this cycle is the fallback.
    if (register_valid_i && (register_rs_valid_i == 2'b11)) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PW'(i);
        if (!reg_hit && valid_q[idx] && !ops_ok_q[idx] && (id_q[idx] == register_id_i)) begin
          reg_hit       = 1'b1;
          rs1_d[idx]    = register_rs0_i;
          rs2_d[idx]    = register_rs1_i;
          ops_ok_d[idx] = 1'b1;
        end
      end
      if (!reg_hit && alloc && (issue_id_i == register_id_i)) begin
        rs1_d[tail_q]    = register_rs0_i;
        rs2_d[tail_q]    = register_rs1_i;
        ops_ok_d[tail_q] = 1'b1;
      end
    end

    if (commit_valid_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PW'(i);
        if (!cmt_hit && valid_q[idx] && !committed_q[idx] && !killed_q[idx] &&
            (id_q[idx] == commit_id_i)) begin
          cmt_hit          = 1'b1;
          killed_d[idx]    = commit_kill_i;
          committed_d[idx] = !commit_kill_i;
        end
      end
      if (!cmt_hit && alloc && (issue_id_i == commit_id_i)) begin
        killed_d[tail_q]    = commit_kill_i;
        committed_d[tail_q] = !commit_kill_i;
      end
    end

    // Start decision looks at this cycle's flag updates so execution begins right after commit.
    unique case (state_q)
      S_IDLE: begin
        if (valid_q[head_q]) begin
          if (killed_d[head_q]) begin
            pop = 1'b1;
          end else if (committed_d[head_q] && ops_ok_d[head_q]) begin
            state_d = S_EXEC;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_RESP: begin
        if (result_ready_i) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end
    count_d = count_q + (PW+1)'(alloc) - (PW+1)'(pop);
  end

  always_comb begin
    exec_res = '0;
    case (f3_q[head_q])
      3'd0:    exec_res = rs1_q[head_q] + rs2_q[head_q];
      3'd1:    exec_res = rs1_q[head_q] ^ rs2_q[head_q];
      3'd2:    exec_res = rs1_q[head_q] - rs2_q[head_q];
      default: exec_res = '0;
    endcase
  end

  assign result_valid_o = (state_q == S_RESP);
  assign result_we_o    = result_valid_o;
  assign result_id_o    = result_valid_o ? id_q[head_q] : '0;
  assign result_data_o  = result_valid_o ? exec_res     : '0;
  assign result_rd_o    = result_valid_o ? rd_q[head_q] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      cnt_q       <= '0;
      valid_q     <= '0;
      ops_ok_q    <= '0;
      committed_q <= '0;
      killed_q    <= '0;
      id_q        <= '{default: '0};
      f3_q        <= '{default: '0};
      rd_q        <= '{default: '0};
      rs1_q       <= '{default: '0};
      rs2_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      ops_ok_q    <= ops_ok_d;
      committed_q <= committed_d;
      killed_q    <= killed_d;
      id_q        <= id_d;
      f3_q        <= f3_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
    end
  end
endmodule

// File: tb/tb_xif_copro_responder.sv
// Bench for xif_copro_responder: directed scenarios plus randomized rounds against
// an in-order result model built from issue/commit bookkeeping.
module tb_xif_copro_responder;
  localparam int LAT = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_valid_i, issue_ready_o, issue_accept_o, issue_writeback_o;
  logic [31:0] issue_instr_i;
  logic [3:0]  issue_id_i;
  logic        register_valid_i, register_ready_o;
  logic [3:0]  register_id_i;
  logic [31:0] register_rs0_i, register_rs1_i;
  logic [1:0]  register_rs_valid_i;
  logic        commit_valid_i, commit_kill_i;
  logic [3:0]  commit_id_i;
  logic        result_valid_o, result_ready_i, result_we_o;
  logic [3:0]  result_id_o;
  logic [31:0] result_data_o;
  logic [4:0]  result_rd_o;

  always #5 clk_i = ~clk_i;

  xif_copro_responder #(.X_ID_WIDTH(4), .XLEN(32), .DEPTH(4), .LATENCY(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .register_valid_i(register_valid_i), .register_ready_o(register_ready_o),
    .register_id_i(register_id_i), .register_rs0_i(register_rs0_i),
    .register_rs1_i(register_rs1_i), .register_rs_valid_i(register_rs_valid_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o),
    .result_rd_o(result_rd_o), .result_we_o(result_we_o)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_results = 0;
  int          exp_q[$];
  logic [2:0]  m_f3 [16];
  logic [4:0]  m_rd [16];
  logic [31:0] m_a [16];
  logic [31:0] m_b [16];
  bit          rand_ready = 1'b0;
  bit          hold = 1'b0;
  logic [3:0]  h_id;
  logic [31:0] h_data;
  logic [4:0]  h_rd;
  int          mon_id;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_acc(input logic [31:0] ins);
    return (ins[6:0] == 7'h0B) && (ins[31:25] == 7'd0) && (ins[14:12] < 3'd3);
  endfunction

  function automatic logic [31:0] model_res(input int id);
    case (m_f3[id])
      3'd0:    return m_a[id] + m_b[id];
      3'd1:    return m_a[id] ^ m_b[id];
      default: return m_a[id] - m_b[id];
    endcase
  endfunction

  // Result monitor: every handshake must match the oldest surviving accepted instruction.
  always @(negedge clk_i) begin
    if (rst_i) begin
      hold = 1'b0;
    end else if (result_valid_o) begin
      if (hold) begin
        chk("stable_id", result_id_o, h_id);
        chk("stable_data", result_data_o, h_data);
        chk("stable_rd", result_rd_o, h_rd);
      end
      if (result_ready_i) begin
        hold = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          mon_id = exp_q.pop_front();
          chk("res_id", result_id_o, mon_id);
          chk("res_data", result_data_o, model_res(mon_id));
          chk("res_rd", result_rd_o, m_rd[mon_id]);
          chk("res_we", result_we_o, 1);
          n_results++;
        end
      end else begin
        hold   = 1'b1;
        h_id   = result_id_o;
        h_data = result_data_o;
        h_rd   = result_rd_o;
      end
    end else begin
      hold = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (rand_ready) result_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic issue_one(input logic [3:0] id, input logic [31:0] ins, input bit with_ops,
                           input logic [31:0] a, input logic [31:0] b, output bit hs);
    issue_valid_i = 1'b1;
    issue_instr_i = ins;
    issue_id_i    = id;
    if (with_ops) begin
      register_valid_i    = 1'b1;
      register_id_i       = id;
      register_rs0_i      = a;
      register_rs1_i      = b;
      register_rs_valid_i = 2'b11;
    end
    #1;
    chk("issue_ready", issue_ready_o, 1);
    chk("accept", issue_accept_o, model_acc(ins));
    chk("writeback", issue_writeback_o, model_acc(ins));
    hs = model_acc(ins);
    if (hs) begin
      exp_q.push_back(int'(id));
      m_f3[id] = ins[14:12];
      m_rd[id] = ins[11:7];
      if (with_ops) begin
        m_a[id] = a;
        m_b[id] = b;
      end
    end
    tick();
    issue_valid_i    = 1'b0;
    register_valid_i = 1'b0;
  endtask

  task automatic send_ops(input logic [3:0] id, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] rsv);
    register_valid_i    = 1'b1;
    register_id_i       = id;
    register_rs0_i      = a;
    register_rs1_i      = b;
    register_rs_valid_i = rsv;
    if (rsv == 2'b11) begin
      m_a[id] = a;
      m_b[id] = b;
    end
    tick();
    register_valid_i = 1'b0;
  endtask

  task automatic commit(input logic [3:0] id, input bit kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
    if (kill) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (exp_q[i] == int'(id)) begin
          exp_q.delete(i);
          break;
        end
      end
    end
    tick();
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    int n = 0;
    while (!result_valid_o && n < budget) begin
      tick();
      n++;
    end
    ok = result_valid_o;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit          hs, ok, same;
    int          base, k, nacc;
    logic [3:0]  acc_ids [4];
    bit          got_ops [4];
    logic [3:0]  id;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [6:0]  f7, op;
    logic [31:0] ins, a, b;

    rst_i = 1'b1;
    issue_valid_i = 0; issue_instr_i = '0; issue_id_i = '0;
    register_valid_i = 0; register_id_i = '0; register_rs0_i = '0; register_rs1_i = '0;
    register_rs_valid_i = '0;
    commit_valid_i = 0; commit_id_i = '0; commit_kill_i = 0;
    result_ready_i = 0;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();

    chk("rst_issue_ready", issue_ready_o, 1);
    chk("rst_result_valid", result_valid_o, 0);
    chk("rst_result_we", result_we_o, 0);
    chk("rst_result_id", result_id_o, 0);
    chk("rst_result_data", result_data_o, 0);
    chk("rst_result_rd", result_rd_o, 0);
    chk("register_ready", register_ready_o, 1);

    // ADD, exact latency from commit
    issue_one(4'd3, 32'h0000000B, 1'b0, '0, '0, hs);
    send_ops(4'd3, 32'd5, 32'd7, 2'b11);
    commit(4'd3, 1'b0);
    chk("lat_at_commit", result_valid_o, 0);
    for (int i = 1; i < LAT; i++) tick();
    chk("lat_early", result_valid_o, 0);
    tick();
    chk("lat_valid", result_valid_o, 1);
    chk("add_id", result_id_o, 4'd3);
    chk("add_data", result_data_o, 32'd12);
    chk("add_we", result_we_o, 1);
    chk("add_rd", result_rd_o, 5'd0);
    result_ready_i = 1'b1;
    drain(20);
    result_ready_i = 1'b0;

    // Rejected funct3
    issue_one(4'd5, 32'h0000700B, 1'b0, '0, '0, hs);
    tick();
    chk("reject_ready", issue_ready_o, 1);

    // SUB wrap, rd=5
    issue_one(4'd1, 32'h0000228B, 1'b0, '0, '0, hs);
    send_ops(4'd1, 32'd0, 32'd1, 2'b11);
    commit(4'd1, 1'b0);
    wait_valid(20, ok);
    chk("sub_seen", ok, 1);
    chk("sub_wrap", result_data_o, 32'hFFFF_FFFF);
    chk("sub_rd", result_rd_o, 5'd5);
    result_ready_i = 1'b1;
    drain(20);
    result_ready_i = 1'b0;

    // Fill the buffer, then drain in order
    base = n_results;
    for (int i = 0; i < 4; i++) begin
      f3  = 3'(i % 3);
      rd  = 5'(i + 1);
      ins = {17'd0, f3, rd, 7'h0B};
      issue_one(4'(i), ins, 1'b0, '0, '0, hs);
      chk("ready_fill", issue_ready_o, (i < 3) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) send_ops(4'(i), $urandom, $urandom, 2'b11);
    for (int i = 0; i < 4; i++) commit(4'(i), 1'b0);
    result_ready_i = 1'b1;
    drain(60);
    tick();
    chk("ready_back", issue_ready_o, 1);
    chk("fill_results", n_results - base, 4);
    result_ready_i = 1'b0;

    // Killed entry produces nothing
    base = n_results;
    issue_one(4'd1, 32'h0000008B, 1'b0, '0, '0, hs);
    issue_one(4'd2, 32'h0000110B, 1'b0, '0, '0, hs);
    send_ops(4'd1, 32'd11, 32'd22, 2'b11);
    send_ops(4'd2, 32'hF0F0_0000, 32'h0FF0_00FF, 2'b11);
    commit(4'd1, 1'b1);
    commit(4'd2, 1'b0);
    result_ready_i = 1'b1;
    drain(30);
    repeat (4) tick();
    chk("kill_results", n_results - base, 1);
    result_ready_i = 1'b0;

    // Backpressure hold, then reset mid-response
    issue_one(4'd7, 32'h0000048B, 1'b0, '0, '0, hs);
    send_ops(4'd7, 32'd100, 32'd23, 2'b11);
    commit(4'd7, 1'b0);
    wait_valid(20, ok);
    chk("hold_seen", ok, 1);
    repeat (5) tick();
    chk("hold_valid", result_valid_o, 1);
    chk("hold_id", result_id_o, 4'd7);
    chk("hold_data", result_data_o, 32'd123);
    chk("hold_rd", result_rd_o, 5'd9);
    rst_i = 1'b1;
    exp_q.delete();
    tick();
    chk("rst_mid_valid", result_valid_o, 0);
    chk("rst_mid_ready", issue_ready_o, 1);
    chk("rst_mid_data", result_data_o, 0);
    rst_i = 1'b0;
    result_ready_i = 1'b1;
    base = n_results;
    repeat (10) tick();
    chk("no_stale", n_results - base, 0);

    // Randomized rounds
    rand_ready = 1'b1;
    for (int r = 0; r < 40; r++) begin
      k = $urandom_range(1, 4);
      nacc = 0;
      for (int j = 0; j < k; j++) begin
        id   = 4'((r * 4 + j) % 16);
        f3   = 3'($urandom_range(0, 3));
        f7   = ($urandom_range(0, 7) == 0) ? 7'h20 : 7'h00;
        op   = ($urandom_range(0, 9) == 0) ? 7'h33 : 7'h0B;
        rd   = 5'($urandom);
        ins  = {f7, 10'($urandom), f3, rd, op};
        same = (j == 0) && ($urandom_range(0, 1) == 1);
        a    = $urandom;
        b    = $urandom;
        issue_one(id, ins, same, a, b, hs);
        if (hs) begin
          acc_ids[nacc] = id;
          got_ops[nacc] = same;
          nacc++;
        end
      end
      for (int j = nacc - 1; j >= 0; j--) begin
        if (!got_ops[j]) begin
          if ($urandom_range(0, 1) == 1) send_ops(acc_ids[j], $urandom, $urandom, 2'b01);
          send_ops(acc_ids[j], $urandom, $urandom, 2'b11);
        end
      end
      for (int j = 0; j < nacc; j++) commit(acc_ids[j], $urandom_range(0, 3) == 0);
      drain(300);
      repeat (4) tick();
    end
    rand_ready = 1'b0;
    result_ready_i = 1'b1;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/xif_copro_responder.md
Name: xif_copro_responder

Overview:
- Coprocessor-side responder for the CV-X-IF core_v_xif bus. It is the far end of the interface the core drives.
- It answers issue requests for a small custom instruction set and collects source operands over the register channel.
- It waits for commit or kill, then executes and returns results in order over the result channel.
- Used as the reference coprocessor in the core_v_xif test environment.

Parameters:
- X_ID_WIDTH, 4, width of instruction id
- XLEN, 32, register/data width
- DEPTH, 4, in-flight instruction buffer entries (power of two, ≥2)
- LATENCY, 2, execute cycles from start to result_valid (≥1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- issue_valid_i  in  1  issue request valid
- issue_ready_o  out  1  responder can take an issue request
- issue_instr_i  in  32  offloaded instruction
- issue_id_i  in  X_ID_WIDTH  instruction id
- issue_accept_o  out  1  instruction accepted (valid while issue_valid_i)
- issue_writeback_o  out  1  accepted instruction will write rd
- register_valid_i  in  1  operand transfer valid
- register_ready_o  out  1  always 1
- register_id_i  in  X_ID_WIDTH  id the operands belong to
- register_rs0_i  in  XLEN  rs1 value
- register_rs1_i  in  XLEN  rs2 value
- register_rs_valid_i  in  2  per-operand valid
- commit_valid_i  in  1  commit transaction valid
- commit_id_i  in  X_ID_WIDTH  id being committed
- commit_kill_i  in  1  1 = discard instruction
- result_valid_o  out  1  result valid
- result_ready_i  in  1  core takes result
- result_id_o  out  X_ID_WIDTH  result id
- result_data_o  out  XLEN  result value
- result_rd_o  out  5  destination register
- result_we_o  out  1  write enable

Behaviour:
- Reset: all buffer entries invalid, count=0, exec counter=0.
  - issue_ready_o=1, result_valid_o=0, result_we_o=0, result_id/data/rd=0.
  - Reset mid-operation discards all in-flight state with no result emitted.
- Issue decode is combinational.
  - Accept when opcode==7'b0001011 and funct7==0 and funct3 ∈ {0,1,2} (0 ADD, 1 XOR, 2 SUB as rs1−rs2). Anything else: accept=0.
  - issue_writeback_o = issue_accept_o.
  - issue_ready_o = (count < DEPTH), derived from registered count.
- Handshake issue_valid_i & issue_ready_o:
  - Accepted: allocate tail entry {id, funct3, rd, ops_ok=0, committed=0, killed=0}.
  - Rejected: no allocation.
- Register channel: on register_valid_i with rs_valid==2'b11, the oldest valid entry with matching id and ops_ok=0 latches both operands and sets ops_ok.
  - No match, or rs_valid≠2'b11: ignored.
  - An issue and a register transfer for the same id in one cycle: the operands are captured into the newly allocated entry.
- Commit: on commit_valid_i, the matching entry sets committed, or killed if commit_kill_i. Same-cycle-as-issue rule as above.
- Head FSM:
  - IDLE → EXEC when head entry is committed and ops_ok.
  - In IDLE, a killed head entry is popped in 1 cycle with no result.
  - EXEC counts LATENCY cycles → RESP; RESP drives result_valid_o=1 with fields held stable until result_ready_i.
  - On handshake: pop head, go to IDLE. Next result no earlier than LATENCY+1 cycles later.
- Result data is computed mod 2^XLEN (wrap-around). result_we_o=1 in RESP.
- Pointers wrap modulo DEPTH. An issue and a pop in the same cycle leave count unchanged.
- The core guarantees unique in-flight ids. Duplicates are not checked.
- A kill arriving for the head while in EXEC is ignored; the committed flag already prevents this case.

Test Plan:
- Reset then issue instr 0x0000000B (ADD, rd=0), id=3 → accept=1, writeback=1.
  - Then register rs 5,7, commit id 3 kill=0 → result_valid exactly LATENCY cycles after commit, id=3, data=12, we=1.
- Issue 0x0000700B (funct3=7) → accept=0, count stays 0, no result ever.
- SUB with rs1=0, rs2=1 → data=0xFFFFFFFF (wrap).
- Issue 4 accepted ids 0..3 without commits → issue_ready=0 after the fourth.
  - Then commit/operand all four with result_ready=1 → results in order 0,1,2,3, and issue_ready returns to 1.
- Ids 1,2 issued; commit 1 with kill=1, commit 2 normal → only id 2 result appears.
- Hold result_ready=0 for 5 cycles → result fields stable.
  - Assert rst_i mid-RESP → result_valid=0 next edge, issue_ready=1, no stale result after reset.
